apb_master_arbiter: RTL

APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

---
 rtl/apb_master_arbiter_if.sv | 31 +++
 rtl/apb_master_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter_if.sv
// Bundle for the two-requester APB master arbiter: requester side plus APB bus.
// Handshakes: a requester holds req high until its done pulse; APB completes an access on any cycle with PSEL & PENABLE & PREADY.
interface apb_master_arbiter_if #(
  parameter int WORD_SIZE = 32
);
  logic [1:0]                 req;
  logic [1:0]                 wr;
  logic [1:0][WORD_SIZE-1:0]  addr;
  logic [1:0][WORD_SIZE-1:0]  wdata;
  logic [1:0]                 gnt;
  logic [1:0]                 done;
  logic                       err;
  logic [WORD_SIZE-1:0]       rdata;
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [WORD_SIZE-1:0]       PADDR;
  logic [WORD_SIZE-1:0]       PWDATA;
  logic                       PREADY;
  logic [WORD_SIZE-1:0]       PRDATA;

  modport master (
    input  req, wr, addr, wdata, PREADY, PRDATA,
    output gnt, done, err, rdata, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req, wr, addr, wdata, PREADY, PRDATA,
    input  gnt, done, err, rdata, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin arbiter driving a single APB master port, all outputs registered.
// Optional ACCESS timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_arbiter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int WORD_SIZE      = 32
) (
  input  logic                 CLK,
  input  logic                 nRST,
  apb_master_arbiter_if.master bus,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_q, last_d;
  logic [1:0]           gnt_q, gnt_d;
  logic [1:0]           done_q, done_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [WORD_SIZE-1:0] paddr_q, paddr_d;
  logic [WORD_SIZE-1:0] pwdata_q, pwdata_d;
  logic                 win;

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    done_d    = done_q;
    rdata_d   = rdata_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    win       = 1'b0;
`ifdef APB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        // With both requesting, the one not served last goes first.
        win = (bus.req == 2'b11) ? ~last_q : bus.req[1];
        if (|bus.req) begin
          owner_d   = win;
          gnt_d     = win ? 2'b10 : 2'b01;
          pwrite_d  = bus.wr[win];
          paddr_d   = bus.addr[win];
          pwdata_d  = bus.wdata[win];
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        if (bus.PREADY) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          done_d    = gnt_q;
          if (!pwrite_q) rdata_d = bus.PRDATA;
          state_d   = DONE;
        end
`ifdef APB_TIMEOUT_EN
        // cnt_q counts finished ACCESS cycles, so this is the last allowed one.
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          done_d    = gnt_q;
          err_d     = 1'b1;
          rdata_d   = '0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      DONE: begin
        done_d  = 2'b00;
        gnt_d   = 2'b00;
        last_d  = owner_q;
        state_d = IDLE;
`ifdef APB_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      gnt_q     <= 2'b00;
      done_q    <= 2'b00;
      rdata_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.rdata   = rdata_q;
  assign bus.PSEL    = psel_q;
  assign bus.PENABLE = penable_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.PADDR   = paddr_q;
  assign bus.PWDATA  = pwdata_q;
  assign state_dbg   = state_q;
`ifdef APB_TIMEOUT_EN
  assign bus.err     = err_q;
`else
  assign bus.err     = 1'b0;
`endif

endmodule
